// File: rtl/perceptron_ctrl.sv
// perceptron_ctrl: byte-oriented command front end for a perceptron core.
//
// Frames arrive as UART bytes: 0xAA sync, then a command byte.
//   AA AD <addr> <data> : write a weight
//   AA AE <addr>        : read a weight, value returned on the tx side
//   AA AF               : start an evaluation, result returned on the tx side
//
// Ports:
//   clk, Rst             clock, synchronous active-high reset
//   rx_valid, rx_data    received byte strobe and value
//   tx_ready             transmitter accepts the byte this cycle
//   tx_valid, tx_data    response byte, held until accepted
//   w_we, w_addr,
//   w_wdata, w_rdata     weight memory port (read data one cycle after address)
//   run_start            one-cycle evaluation start pulse
//   run_done, run_result evaluation completion strobe and result
//
// Build option: define PERCEPTRON_CTRL_ACK_EN to answer every weight write
// with a 0x55 acknowledge byte.

module perceptron_ctrl #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 10000
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              w_we,
  output logic [ADDR_W-1:0] w_addr,
  output logic [7:0]        w_wdata,
  input  logic [7:0]        w_rdata,
  output logic              run_start,
  input  logic              run_done,
  input  logic [7:0]        run_result
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [7:0] ByteSync  = 8'hAA;
  localparam logic [7:0] ByteWrite = 8'hAD;
  localparam logic [7:0] ByteRead  = 8'hAE;
  localparam logic [7:0] ByteRun   = 8'hAF;
  localparam logic [7:0] ByteAck   = 8'h55;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StData,
    StWrite,
    StRdwait,
    StRunwait,
    StTx
  } state_t;

  state_t             state;
  logic               is_read;   // frame in progress is a read
  logic               rd_phase;  // second RDWAIT cycle: w_rdata is valid
  logic [CNT_W-1:0]   tmo_cnt;
  logic               tmo_hit;

  // Last idle cycle of the inter-byte window in CMD/ADDR/DATA.
  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (Rst) begin
      state     <= StIdle;
      is_read   <= 1'b0;
      rd_phase  <= 1'b0;
      tmo_cnt   <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      w_we      <= 1'b0;
      w_addr    <= '0;
      w_wdata   <= 8'h00;
      run_start <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      w_we      <= 1'b0;
      run_start <= 1'b0;

      unique case (state)
        StIdle: begin
          tmo_cnt <= '0;
          if (rx_valid && rx_data == ByteSync) begin
            state <= StCmd;
          end
        end

        StCmd: begin
          if (rx_valid) begin
            tmo_cnt <= '0;
            unique case (rx_data)
              ByteSync:  state <= StCmd;  // resync on repeated sync bytes
              ByteWrite: begin
                is_read <= 1'b0;
                state   <= StAddr;
              end
              ByteRead: begin
                is_read <= 1'b1;
                state   <= StAddr;
              end
              ByteRun: begin
                run_start <= 1'b1;
                state     <= StRunwait;
              end
              default:   state <= StIdle;
            endcase
          end else if (tmo_hit) begin
            tmo_cnt <= '0;
            state   <= StIdle;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        StAddr: begin
          if (rx_valid) begin
            tmo_cnt <= '0;
            w_addr  <= rx_data[ADDR_W-1:0];
            if (is_read) begin
              rd_phase <= 1'b0;
              state    <= StRdwait;
            end else begin
              state <= StData;
            end
          end else if (tmo_hit) begin
            tmo_cnt <= '0;
            state   <= StIdle;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        StData: begin
          if (rx_valid) begin
            tmo_cnt <= '0;
            w_wdata <= rx_data;
            w_we    <= 1'b1;
            state   <= StWrite;
          end else if (tmo_hit) begin
            tmo_cnt <= '0;
            state   <= StIdle;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        StWrite: begin
          tmo_cnt <= '0;
`ifdef PERCEPTRON_CTRL_ACK_EN
          tx_data  <= ByteAck;
          tx_valid <= 1'b1;
          state    <= StTx;
`else
          state <= StIdle;
`endif
        end

        // First cycle presents w_addr to the memory, second captures w_rdata.
        StRdwait: begin
          tmo_cnt <= '0;
          if (rd_phase) begin
            rd_phase <= 1'b0;
            tx_data  <= w_rdata;
            tx_valid <= 1'b1;
            state    <= StTx;
          end else begin
            rd_phase <= 1'b1;
          end
        end

        // run_done is ignored during the run_start cycle itself.
        StRunwait: begin
          tmo_cnt <= '0;
          if (!run_start && run_done) begin
            tx_data  <= run_result;
            tx_valid <= 1'b1;
            state    <= StTx;
          end
        end

        StTx: begin
          tmo_cnt <= '0;
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= StIdle;
          end
        end

        default: begin
          tmo_cnt  <= '0;
          tx_valid <= 1'b0;
          state    <= StIdle;
        end
      endcase
    end
  end

`ifndef PERCEPTRON_CTRL_ACK_EN
  // The acknowledge constant is only used in the ACK build.
  logic unused_ack;
  assign unused_ack = ^ByteAck;
`endif

endmodule

// File: tb/tb_perceptron_ctrl.sv
// Directed self-checking bench for perceptron_ctrl.
// Includes a synchronous weight memory model and an evaluation model that
// answers each run_start with run_done/0x7E twenty cycles later.

module tb_perceptron_ctrl;

  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              Rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_wdata;
  logic [7:0]        w_rdata = 8'h00;
  logic              run_start;
  logic              run_done = 1'b0;
  logic [7:0]        run_result = 8'h00;

  perceptron_ctrl #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .Rst        (Rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .w_we       (w_we),
    .w_addr     (w_addr),
    .w_wdata    (w_wdata),
    .w_rdata    (w_rdata),
    .run_start  (run_start),
    .run_done   (run_done),
    .run_result (run_result)
  );

  always #5 clk = ~clk;

  // Weight memory model: synchronous write, one-cycle read latency.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (w_we) mem[w_addr] <= w_wdata;
    w_rdata <= mem[w_addr];
  end

  // Evaluation model; deliberately not reset so a late run_done can hit IDLE.
  int run_cd = 0;
  always @(posedge clk) begin
    run_done <= 1'b0;
    if (run_start) begin
      run_cd <= 20;
    end else if (run_cd > 0) begin
      run_cd <= run_cd - 1;
      if (run_cd == 1) begin
        run_done   <= 1'b1;
        run_result <= 8'h7E;
      end
    end
  end

  // Event monitors.
  int         we_cnt  = 0;
  int         run_cnt = 0;
  int         tx_cnt  = 0;
  logic [7:0] we_addr_l = 8'h00;
  logic [7:0] we_data_l = 8'h00;
  logic [7:0] tx_last   = 8'h00;
  always @(posedge clk) begin
    if (w_we) begin
      we_cnt    <= we_cnt + 1;
      we_addr_l <= 8'(w_addr);
      we_data_l <= w_wdata;
    end
    if (run_start) run_cnt <= run_cnt + 1;
    if (tx_valid && tx_ready) begin
      tx_cnt  <= tx_cnt + 1;
      tx_last <= tx_data;
    end
  end

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; byte is sampled by the next posedge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tx();
    for (int i = 0; i < 100; i++) begin
      if (tx_valid) break;
      @(negedge clk);
    end
    check("wait_tx", 32'(tx_valid), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_valid"},  32'(tx_valid),  32'd0);
    check({tag, "_tx_data"},   32'(tx_data),   32'h00);
    check({tag, "_w_we"},      32'(w_we),      32'd0);
    check({tag, "_w_addr"},    32'(w_addr),    32'd0);
    check({tag, "_w_wdata"},   32'(w_wdata),   32'h00);
    check({tag, "_run_start"}, 32'(run_start), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int t0;
    int r0;
    logic [7:0] wr_seq [7];
    wr_seq = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAD, 8'h01};

    Rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    idle(3);
    check_reset_outputs("rst");
    Rst = 1'b0;
    idle(2);

    // Write with repeated sync bytes.
    w0 = we_cnt;
    t0 = tx_cnt;
    foreach (wr_seq[i]) send_byte(wr_seq[i]);
    send_byte(8'h00);
    check("wr_we",    32'(w_we),    32'd1);
    check("wr_addr",  32'(w_addr),  32'd1);
    check("wr_wdata", 32'(w_wdata), 32'h00);
    idle(1);
    check("wr_we_off", 32'(w_we), 32'd0);
`ifdef PERCEPTRON_CTRL_ACK_EN
    check("wr_ack_valid", 32'(tx_valid), 32'd1);
    check("wr_ack_data",  32'(tx_data),  32'h55);
    idle(1);
    check("wr_ack_drop", 32'(tx_valid), 32'd0);
    check("wr_ack_cnt",  32'(tx_cnt - t0), 32'd1);
`else
    check("wr_no_tx", 32'(tx_valid), 32'd0);
    idle(1);
    check("wr_no_tx_cnt", 32'(tx_cnt - t0), 32'd0);
`endif
    idle(1);
    check("wr_pulses", 32'(we_cnt - w0), 32'd1);

    // Trailing sync byte enters CMD: a bare AE then reads mem[1].
    send_byte(8'hAA);
    send_byte(8'hAE);
    send_byte(8'h01);
    wait_tx();
    check("rd1_data", 32'(tx_data), 32'h00);
    idle(2);

    // Write 0x5C to address 3, then read it back via address 0x13.
    send_byte(8'hAA);
    send_byte(8'hAD);
    send_byte(8'h03);
    send_byte(8'h5C);
    idle(4);
    check("wr3_addr", 32'(we_addr_l), 32'h03);
    check("wr3_data", 32'(we_data_l), 32'h5C);
    tx_ready = 1'b0;
    t0 = tx_cnt;
    send_byte(8'hAA);
    send_byte(8'hAE);
    send_byte(8'h13);
    check("rd_lat_n1", 32'(tx_valid), 32'd0);
    idle(1);
    check("rd_lat_n2", 32'(tx_valid), 32'd0);
    idle(1);
    check("rd_lat_n3", 32'(tx_valid), 32'd1);
    check("rd_data",   32'(tx_data),  32'h5C);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("rd_hold_valid", 32'(tx_valid), 32'd1);
      check("rd_hold_data",  32'(tx_data),  32'h5C);
    end
    tx_ready = 1'b1;
    idle(1);
    check("rd_drop",  32'(tx_valid), 32'd0);
    check("rd_cnt",   32'(tx_cnt - t0), 32'd1);
    check("rd_last",  32'(tx_last), 32'h5C);

    // Run; a write frame sent during RUNWAIT must be dropped.
    w0 = we_cnt;
    r0 = run_cnt;
    send_byte(8'hAA);
    send_byte(8'hAF);
    check("run_start_on", 32'(run_start), 32'd1);
    idle(1);
    check("run_start_off", 32'(run_start), 32'd0);
    send_byte(8'hAA);
    send_byte(8'hAD);
    send_byte(8'h05);
    send_byte(8'h66);
    check("run_tx_early", 32'(tx_valid), 32'd0);
    wait_tx();
    check("run_result", 32'(tx_data), 32'h7E);
    idle(1);
    check("run_tx_drop", 32'(tx_valid), 32'd0);
    check("run_pulses",  32'(run_cnt - r0), 32'd1);
    check("run_no_we",   32'(we_cnt - w0), 32'd0);

    // Bad command returns to IDLE: the following bare AD frame is ignored.
    w0 = we_cnt;
    t0 = tx_cnt;
    r0 = run_cnt;
    send_byte(8'hAA);
    send_byte(8'h42);
    send_byte(8'hAD);
    send_byte(8'h07);
    send_byte(8'h99);
    idle(3);
    check("bad_we",  32'(we_cnt - w0), 32'd0);
    check("bad_tx",  32'(tx_cnt - t0), 32'd0);
    check("bad_run", 32'(run_cnt - r0), 32'd0);

    // Timeout after the address byte: full window abandons the frame.
    send_byte(8'hAA);
    send_byte(8'hAD);
    send_byte(8'h02);
    idle(TIMEOUT);
    send_byte(8'h11);
    idle(3);
    check("tmo_no_we", 32'(we_cnt - w0), 32'd0);

    // One cycle short of the window still completes the frame.
    send_byte(8'hAA);
    send_byte(8'hAD);
    idle(TIMEOUT - 1);
    send_byte(8'h02);
    idle(TIMEOUT - 1);
    send_byte(8'h11);
    idle(4);
    check("tmo_edge_we",   32'(we_cnt - w0), 32'd1);
    check("tmo_edge_addr", 32'(we_addr_l), 32'h02);
    check("tmo_edge_data", 32'(we_data_l), 32'h11);

    // Normal write after the timeout.
    send_byte(8'hAA);
    send_byte(8'hAD);
    send_byte(8'h02);
    send_byte(8'h11);
    idle(4);
    check("post_tmo_we", 32'(we_cnt - w0), 32'd2);

    // Reset between address and data bytes.
    w0 = we_cnt;
    send_byte(8'hAA);
    send_byte(8'hAD);
    send_byte(8'h04);
    Rst = 1'b1;
    idle(1);
    check_reset_outputs("rst_mid");
    Rst = 1'b0;
    send_byte(8'h33);
    idle(3);
    check("rst_mid_no_we", 32'(we_cnt - w0), 32'd0);

    // Reset during a run: the late run_done must not produce tx traffic.
    t0 = tx_cnt;
    r0 = run_cnt;
    send_byte(8'hAA);
    send_byte(8'hAF);
    Rst = 1'b1;
    idle(1);
    check("rst_run_start", 32'(run_start), 32'd0);
    Rst = 1'b0;
    idle(40);
    check("rst_run_tx",    32'(tx_cnt - t0), 32'd0);
    check("rst_run_valid", 32'(tx_valid), 32'd0);
    check("rst_run_pulse", 32'(run_cnt - r0), 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/perceptron_ctrl.md
PERCEPTRON_CTRL -- requirements
Module: perceptron_ctrl

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, default 4, weight address width.
- TIMEOUT, default 10000, inter-byte timeout in clk cycles.
REQ-002 Ports SHALL be:
- clk  in  1  system clock; all logic on rising edge.
- Rst  in  1  reset, synchronous, active-high.
- rx_valid  in  1  one-cycle strobe, received UART byte.
- rx_data  in  8  received byte, valid with rx_valid.
- tx_ready  in  1  UART transmitter accepts byte this cycle.
- tx_valid  out  1  response byte valid.
- tx_data  out  8  response byte.
- w_we  out  1  weight write strobe.
- w_addr  out  ADDR_W  weight address.
- w_wdata  out  8  weight write data.
- w_rdata  in  8  weight read data, valid one cycle after w_addr.
- run_start  out  1  one-cycle pulse, start perceptron evaluation.
- run_done  in  1  evaluation complete strobe.
- run_result  in  8  evaluation result, valid with run_done.
REQ-003 There SHALL be one clock (clk); reset is synchronous and active-high (Rst).

Function
REQ-004 FSM states SHALL be IDLE, CMD, ADDR, DATA, WRITE, RDWAIT, RUNWAIT, TX.
REQ-005 IDLE: rx_valid with 0xAA -> CMD; any other byte ignored.
REQ-006 CMD: 0xAA stays in CMD (resync); 0xAD (write) or 0xAE (read) -> ADDR; 0xAF (run) -> RUNWAIT; any other byte -> IDLE with no response.
REQ-007 ADDR: byte accepted, low ADDR_W bits latched to w_addr, upper bits ignored; write -> DATA, read -> RDWAIT.
REQ-008 DATA: byte latched to w_wdata -> WRITE; w_we high exactly one cycle, the cycle after the data byte's rx_valid.
REQ-009 Read latency: addr byte at cycle N, w_rdata captured at N+2, tx_valid asserted from N+3 with the captured value.
REQ-010 Run: run_start pulses the cycle after the 0xAF rx_valid; run_done is sampled from the following cycle onward; run_result is captured on run_done -> TX.
REQ-011 TX: tx_valid and tx_data held stable until a cycle with tx_ready high; tx_valid low the next cycle; state -> IDLE.
REQ-012 rx_valid received in WRITE, RDWAIT, RUNWAIT or TX SHALL be dropped without changing state or outputs.
REQ-013 Timeout counter SHALL clear on every accepted rx_valid; in CMD/ADDR/DATA, TIMEOUT cycles without rx_valid -> IDLE, no write, no response.
REQ-014 RUNWAIT and TX SHALL have no timeout.
REQ-015 w_we, run_start and tx_valid SHALL never be high outside the states named above.

Reset
REQ-016 With Rst high at a clk edge: state=IDLE; tx_valid=0, tx_data=0x00, w_we=0, w_addr=0, w_wdata=0, run_start=0, timeout counter=0.
REQ-017 Rst asserted mid-frame or mid-run SHALL abandon the operation; no w_we, run_start or tx_valid is produced on or after the reset cycle.

Configuration
REQ-018 Macro PERCEPTRON_CTRL_ACK_EN defined: after the WRITE cycle, the FSM enters TX with tx_data=0x55 (write acknowledge).
REQ-019 Macro PERCEPTRON_CTRL_ACK_EN undefined: WRITE -> IDLE directly, and writes produce no tx traffic.

Verification
REQ-020 Write: bytes AA AA AA AA AA AD 01 00 -> single w_we pulse with w_addr=1, w_wdata=0x00; then tx 0x55 if ACK_EN, otherwise no tx; trailing AA -> CMD.
REQ-021 Read: write AA AD 03 5C, then send AA AE 13, model returns mem[3] -> tx_data=0x5C (upper address bits ignored), tx_valid held across 5 cycles of tx_ready=0.
REQ-022 Run: AA AF, model raises run_done with run_result=0x7E after 20 cycles -> exactly one run_start pulse, then tx 0x7E; bytes sent during RUNWAIT are ignored.
REQ-023 Errors: AA 42 -> IDLE, no outputs; AA AD 02 followed by TIMEOUT idle cycles -> IDLE, no w_we; a subsequent AA AD 02 11 writes normally.
REQ-024 Reset: Rst pulsed between addr and data bytes of a write -> no w_we; all outputs at their REQ-016 values.
